// File: rtl/instr_encoder_if.sv
// Request/response bundle for the MIPS instruction encoder.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready handshakes carried through unchanged.
// The master modport is the producer/consumer side that drives requests and
// accepts words; the slave modport is the encoder itself.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              full;
  logic              err;

  modport master (
    output start, in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt,
           in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_data, out_addr, full, err
  );

  modport slave (
    input  start, in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt,
           in_imm, in_target, out_ready,
    output in_ready, out_valid, out_data, out_addr, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming MIPS encoder: field-level requests -> 32-bit words tagged with their word address.
// Latency: 1 cycle from accept to out_valid; 1 word/cycle when the consumer keeps out_ready high.
// Backpressure: single output register, in_ready drops while the word is held or capacity is reached.
// Ports: clk, rst_n (synchronous, active low), bus (instr_encoder_if.slave: start,
// in_* request, out_* word stream, full, err).
// Optional build macro BRANCH_REL_EN: BEQ/BNE in_imm is an absolute word address and is
// converted to a PC-relative offset; without it in_imm is copied verbatim.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_encoder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [4:0] M_ADD  = 5'd0;
  localparam logic [4:0] M_SUB  = 5'd1;
  localparam logic [4:0] M_AND  = 5'd2;
  localparam logic [4:0] M_OR   = 5'd3;
  localparam logic [4:0] M_SLT  = 5'd4;
  localparam logic [4:0] M_SLL  = 5'd5;
  localparam logic [4:0] M_SRL  = 5'd6;
  localparam logic [4:0] M_JR   = 5'd7;
  localparam logic [4:0] M_LW   = 5'd8;
  localparam logic [4:0] M_SW   = 5'd9;
  localparam logic [4:0] M_J    = 5'd10;
  localparam logic [4:0] M_JAL  = 5'd11;
  localparam logic [4:0] M_BEQ  = 5'd12;
  localparam logic [4:0] M_BNE  = 5'd13;
  localparam logic [4:0] M_ADDI = 5'd14;
  localparam logic [4:0] M_LUI  = 5'd15;
  localparam logic [4:0] M_ORI  = 5'd16;
  localparam logic [4:0] M_SLTI = 5'd17;
  localparam logic [4:0] M_ANDI = 5'd18;

  // One past the last legal word address; next_addr carries an extra bit to reach it.
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_d;
  logic [ADDR_W:0]   next_addr;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              full_w;
  logic              supported;
  logic              accept;
  logic              emit;
  logic [15:0]       branch_imm;
  logic [31:0]       enc;

  assign full_w    = (next_addr == CAP);
  assign supported = (bus.in_mnem <= M_ANDI);
  // start wins over any request presented in the same cycle.
  assign bus.in_ready = !bus.start && !full_w &&
                        (state == S_EMPTY || (state == S_HOLD && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;
  assign emit   = accept && supported;

`ifdef BRANCH_REL_EN
  // Offset is relative to the slot after the branch (its PC+4 in words).
  assign branch_imm = bus.in_imm - (16'(next_addr) + 16'd1);
`else
  assign branch_imm = bus.in_imm;
`endif

  // Field packing; fields a format does not use are forced to zero.
  always_comb begin
    enc = '0;
    case (bus.in_mnem)
      M_ADD:  enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100000};
      M_SUB:  enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100010};
      M_AND:  enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100100};
      M_OR:   enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100101};
      M_SLT:  enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b101010};
      M_SLL:  enc = {6'b000000, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'b000000};
      M_SRL:  enc = {6'b000000, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'b000010};
      M_JR:   enc = {6'b000000, bus.in_rs, 15'd0, 6'b001000};
      M_LW:   enc = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
      M_SW:   enc = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
      M_J:    enc = {6'b000010, bus.in_target};
      M_JAL:  enc = {6'b000011, bus.in_target};
      M_BEQ:  enc = {6'b000100, bus.in_rs, bus.in_rt, branch_imm};
      M_BNE:  enc = {6'b000101, bus.in_rs, bus.in_rt, branch_imm};
      M_ADDI: enc = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
      M_LUI:  enc = {6'b001111, 5'd0, bus.in_rt, bus.in_imm};
      M_ORI:  enc = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm};
      M_SLTI: enc = {6'b001010, bus.in_rs, bus.in_rt, bus.in_imm};
      M_ANDI: enc = {6'b001100, bus.in_rs, bus.in_rt, bus.in_imm};
      default: enc = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_EMPTY;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    if (bus.start) begin
      state_d = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (emit) state_d = S_HOLD;
        // An unsupported accept in HOLD still retires the held word.
        S_HOLD:  if (bus.out_ready && !emit) state_d = full_w ? S_FULL : S_EMPTY;
        S_FULL:  state_d = S_FULL;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      addr_q    <= '0;
      next_addr <= '0;
      err_q     <= 1'b0;
    end else if (bus.start) begin
      next_addr <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      if (supported) begin
        data_q    <= enc;
        addr_q    <= next_addr[ADDR_W-1:0];
        next_addr <= next_addr + 1'b1;
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid = (state == S_HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_addr  = addr_q;
  assign bus.full      = full_w;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized stream
// compared against a transaction-level reference model (encoding from field rules,
// word count and held-word flag). A second instance with ADDR_W=2 covers capacity.
module tb_instr_encoder;

  localparam int CAP = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(8)) bus ();
  instr_encoder_if #(.ADDR_W(2)) bus_s ();

  instr_encoder #(.ADDR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  instr_encoder #(.ADDR_W(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_held;
  logic [31:0] m_word;
  int          m_addr;
  int          m_count;
  bit          m_err;
  bit          seen_in_ready;
  bit          exp_in_ready;

  function automatic logic [31:0] ref_enc(input logic [4:0] mn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [15:0] imm,
                                          input logic [25:0] tgt, input int at);
    int op;
    int fn;
    int im;
    logic [31:0] w;
    w  = 32'd0;
    op = 0;
    fn = 0;
    im = int'(imm);
    case (mn)
      5'd0: fn = 32;
      5'd1: fn = 34;
      5'd2: fn = 36;
      5'd3: fn = 37;
      5'd4: fn = 42;
      5'd6: fn = 2;
      5'd7: fn = 8;
      5'd8: op = 35;
      5'd9: op = 43;
      5'd10: op = 2;
      5'd11: op = 3;
      5'd12: op = 4;
      5'd13: op = 5;
      5'd14: op = 8;
      5'd15: op = 15;
      5'd16: op = 13;
      5'd17: op = 10;
      5'd18: op = 12;
      default: ;
    endcase
`ifdef BRANCH_REL_EN
    if (mn == 5'd12 || mn == 5'd13) im = (im - (at + 1)) & 32'hFFFF;
`else
    if (at < 0) im = 0;
`endif
    if (mn <= 5'd4)
      w = 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + 32'(rd) * 32'h800 + 32'(fn);
    else if (mn <= 5'd6)
      w = 32'(rt) * 32'h10000 + 32'(rd) * 32'h800 + 32'(sh) * 32'h40 + 32'(fn);
    else if (mn == 5'd7)
      w = 32'(rs) * 32'h200000 + 32'(fn);
    else if (mn == 5'd10 || mn == 5'd11)
      w = 32'(op) * 32'h4000000 + 32'(tgt);
    else if (mn == 5'd15)
      w = 32'(op) * 32'h4000000 + 32'(rt) * 32'h10000 + 32'(im);
    else if (mn <= 5'd18)
      w = 32'(op) * 32'h4000000 + 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + 32'(im);
    return w;
  endfunction

  task automatic model_clear();
    m_held  = 0;
    m_count = 0;
    m_err   = 0;
    m_word  = '0;
    m_addr  = 0;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.in_valid = 0; bus.in_mnem = '0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_rd = '0; bus.in_shamt = '0; bus.in_imm = '0; bus.in_target = '0; bus.out_ready = 1;
    bus_s.start = 0; bus_s.in_valid = 0; bus_s.in_mnem = '0; bus_s.in_rs = '0; bus_s.in_rt = '0;
    bus_s.in_rd = '0; bus_s.in_shamt = '0; bus_s.in_imm = '0; bus_s.in_target = '0;
    bus_s.out_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Drives one cycle on the main instance and advances the model across the edge.
  task automatic step(input bit st, input bit v, input logic [4:0] mn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [25:0] tgt, input bit ordy);
    bit acc;
    @(negedge clk);
    bus.start = st; bus.in_valid = v; bus.in_mnem = mn; bus.in_rs = rs; bus.in_rt = rt;
    bus.in_rd = rd; bus.in_shamt = sh; bus.in_imm = imm; bus.in_target = tgt; bus.out_ready = ordy;
    #1;
    seen_in_ready = bus.in_ready;
    exp_in_ready  = !st && (m_count < CAP) && (!m_held || ordy);
    acc = v && exp_in_ready;
    @(posedge clk);
    if (st) begin
      m_held = 0; m_count = 0; m_err = 0;
    end else begin
      if (m_held && ordy) m_held = 0;
      if (acc) begin
        if (mn <= 5'd18) begin
          m_word = ref_enc(mn, rs, rt, rd, sh, imm, tgt, m_count);
          m_addr = m_count % CAP;
          m_count++;
          m_held = 1;
        end else begin
          m_err = 1;
        end
      end
    end
    #1;
  endtask

  task automatic pulse_start();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b data=%h addr=%h want 0/0/0", bus.out_valid, bus.out_data, bus.out_addr);
    end
    n_tests++;
    if (bus.full !== 1'b0 || bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags: full=%b err=%b in_ready=%b want 0/0/1", bus.full, bus.err, bus.in_ready);
    end
  endtask

  task automatic test_add();
    step(0, 1, 5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 1);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00221820 || bus.out_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL add: valid=%b data=%h addr=%0d want 1/00221820/0", bus.out_valid, bus.out_data, bus.out_addr);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h00031100; exp_w[1] = 32'h8FA80004; exp_w[2] = 32'h03E00008; exp_w[3] = 32'h08000010;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: step(0, 1, 5'd5, 5'd0, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 1);
        1: step(0, 1, 5'd8, 5'd29, 5'd8, 5'd0, 5'd0, 16'h4, 26'h0, 1);
        2: step(0, 1, 5'd7, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1);
        default: step(0, 1, 5'd10, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1);
      endcase
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w[i] || bus.out_addr !== 8'(i)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: valid=%b data=%h addr=%0d want 1/%h/%0d", i, bus.out_valid, bus.out_data, bus.out_addr, exp_w[i], i);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] w0, w1;
    w0 = ref_enc(5'd0, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 0);
    w1 = ref_enc(5'd1, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0, 1);
    pulse_start();
    step(0, 1, 5'd0, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 5'd1, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0, 0);
      n_tests++;
      if (seen_in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== w0 || bus.out_addr !== 8'd0) begin
        n_fail++;
        $display("FAIL stall[%0d]: in_ready=%b valid=%b data=%h addr=%0d want 0/1/%h/0", i, seen_in_ready, bus.out_valid, bus.out_data, bus.out_addr, w0);
      end
    end
    step(0, 1, 5'd1, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0, 1);
    n_tests++;
    if (seen_in_ready !== 1'b1 || bus.out_data !== w1 || bus.out_addr !== 8'd1) begin
      n_fail++;
      $display("FAIL stall_resume: in_ready=%b data=%h addr=%0d want 1/%h/1", seen_in_ready, bus.out_data, bus.out_addr, w1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_err();
    pulse_start();
    step(0, 1, 5'd2, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1);
    step(0, 1, 5'd25, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1);
    n_tests++;
    if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_set: err=%b valid=%b want 1/0", bus.err, bus.out_valid);
    end
    step(0, 1, 5'd3, 5'd2, 5'd2, 5'd2, 5'd0, 16'h0, 26'h0, 1);
    n_tests++;
    if (bus.out_addr !== 8'd1 || bus.out_data !== ref_enc(5'd3, 5'd2, 5'd2, 5'd2, 5'd0, 16'h0, 26'h0, 1) || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_contig: addr=%0d data=%h err=%b want addr 1 err 1", bus.out_addr, bus.out_data, bus.err);
    end
    // start presented together with a request: request must not be taken.
    step(1, 1, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 0);
    n_tests++;
    if (seen_in_ready !== 1'b0 || bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clear: in_ready=%b err=%b valid=%b want 0/0/0", seen_in_ready, bus.err, bus.out_valid);
    end
    step(0, 1, 5'd4, 5'd3, 5'd3, 5'd3, 5'd0, 16'h0, 26'h0, 1);
    n_tests++;
    if (bus.out_addr !== 8'd0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL start_addr: addr=%0d valid=%b want 0/1", bus.out_addr, bus.out_valid);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_branch();
    logic [31:0] exp_w;
`ifdef BRANCH_REL_EN
    exp_w = 32'h1022FFFC;
`else
    exp_w = 32'h10220002;
`endif
    pulse_start();
    for (int i = 0; i < 5; i++) step(0, 1, 5'd14, 5'd1, 5'd1, 5'd0, 5'd0, 16'(i), 26'h0, 1);
    step(0, 1, 5'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h2, 26'h0, 1);
    n_tests++;
    if (bus.out_data !== exp_w || bus.out_addr !== 8'd5) begin
      n_fail++;
      $display("FAIL beq: data=%h addr=%0d want %h/5", bus.out_data, bus.out_addr, exp_w);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    pulse_start();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 22)),
           5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
           $urandom_range(0, 3) != 0);
      n_tests++;
      if (seen_in_ready !== exp_in_ready || bus.out_valid !== m_held || bus.err !== m_err ||
          bus.full !== (m_count == CAP) ||
          (m_held && (bus.out_data !== m_word || bus.out_addr !== 8'(m_addr)))) begin
        n_fail++;
        errs++;
        if (errs <= 5)
          $display("FAIL random[%0d]: rdy=%b/%b valid=%b/%b data=%h/%h addr=%0d/%0d err=%b/%b (got/want)",
                   c, seen_in_ready, exp_in_ready, bus.out_valid, m_held, bus.out_data, m_word,
                   bus.out_addr, m_addr, bus.err, m_err);
      end
    end
  endtask

  task automatic test_mid_reset();
    pulse_start();
    step(0, 1, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 0);
    do_reset();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b data=%h err=%b want 0/0/0", bus.out_valid, bus.out_data, bus.err);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_s.in_valid = 1; bus_s.in_mnem = 5'd0; bus_s.in_rd = 5'(k); bus_s.out_ready = 1;
      @(posedge clk);
      #1;
      n_tests++;
      if (bus_s.out_valid !== 1'b1 || bus_s.out_addr !== 2'(k) ||
          bus_s.out_data !== ref_enc(5'd0, 5'd0, 5'd0, 5'(k), 5'd0, 16'h0, 26'h0, k)) begin
        n_fail++;
        $display("FAIL full_fill[%0d]: valid=%b addr=%0d data=%h", k, bus_s.out_valid, bus_s.out_addr, bus_s.out_data);
      end
    end
    n_tests++;
    if (bus_s.full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_flag: full=%b want 1", bus_s.full);
    end
    @(negedge clk);
    bus_s.in_rd = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (bus_s.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL full_stall[%0d]: in_ready=%b want 0", i, bus_s.in_ready);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus_s.out_valid !== 1'b0 || bus_s.full !== 1'b1) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: valid=%b full=%b want 0/1", i, bus_s.out_valid, bus_s.full);
      end
      @(negedge clk);
    end
    bus_s.start = 1;
    #1;
    n_tests++;
    if (bus_s.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_start_rdy: in_ready=%b want 0", bus_s.in_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus_s.full !== 1'b0 || bus_s.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_cleared: full=%b valid=%b want 0/0", bus_s.full, bus_s.out_valid);
    end
    @(negedge clk);
    bus_s.start = 0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus_s.out_valid !== 1'b1 || bus_s.out_addr !== 2'd0 ||
        bus_s.out_data !== ref_enc(5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 16'h0, 26'h0, 0)) begin
      n_fail++;
      $display("FAIL full_resume: valid=%b addr=%0d data=%h", bus_s.out_valid, bus_s.out_addr, bus_s.out_data);
    end
    @(negedge clk);
    bus_s.in_valid = 0;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_err();
    test_branch();
    test_full();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
